weight_rom_stream_ctrl: RTL and testbench

//   Sequencer for one 2-cycle-latency parameter ROM (e.g. an attention key/query/value weight ROM).

---
 rtl/weight_stream_pkg.sv | 20 ++
 rtl/weight_stream_fifo.sv | 61 ++++++
 rtl/weight_rom_stream_ctrl.sv | 173 +++++++++++++++++
 tb/tb_weight_rom_stream_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_pkg.sv
// Shared types and defaults for the weight ROM stream controller.
//   state_t : sequencer states; the top maps them onto plain 2-bit constants
//   tag_t   : per-issue tag {valid, last} carried alongside the ROM pipeline
package weight_stream_pkg;

  localparam int unsigned ROM_LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/weight_stream_fifo.sv
// Small synchronous skid FIFO that absorbs ROM words while the consumer stalls.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (flushes contents)
//   i_wr        push i_wdata this cycle
//   i_wdata     word to push
//   i_rd        pop the head this cycle (caller guarantees not empty)
//   o_head      current head word
//   o_count     number of stored words
//   o_empty     no stored words
// Push and pop in the same cycle are both performed.
module weight_stream_fifo #(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (i_rd) r_rptr <= ptr_inc(r_rptr);
      case ({i_wr, i_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/weight_rom_stream_ctrl.sv
// Sequencer for one fixed-latency parameter ROM. Walks addresses 0..DEPTH-1 for a
// programmed number of passes and streams the words out over valid/ready without
// ever dropping a word under backpressure.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (abandons any job)
//   i_start           begin a job (sampled only in IDLE)
//   i_num_passes      passes per job, captured on an accepted start
//   o_busy            job in progress
//   o_done            one-cycle pulse at end of job
//   o_rom_addr/o_rom_ce/i_rom_q   ROM port 0
//   o_data_out, o_data_out_last, o_data_out_valid, i_data_out_ready   output stream
//   o_stall_cycles    backpressure cycle count
// Build option: define WEIGHT_STREAM_STALL_CNT_EN to build the stall counter;
// otherwise o_stall_cycles is tied to zero.
module weight_rom_stream_ctrl
  import weight_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned DEPTH       = 576,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int unsigned ROM_LATENCY = ROM_LATENCY_DEFAULT,
  parameter int unsigned PASS_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [PASS_WIDTH-1:0] i_num_passes,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  output logic                  o_rom_ce,
  input  logic [DATA_WIDTH-1:0] i_rom_q,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_out_last,
  output logic                  o_data_out_valid,
  input  logic                  i_data_out_ready,
  output logic [31:0]           o_stall_cycles
);

  localparam int unsigned FIFO_DEPTH = ROM_LATENCY + 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W      = $clog2(2 * FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [PASS_WIDTH-1:0] r_pass;
  logic [PASS_WIDTH-1:0] r_num_passes;
  logic                  r_ce;
  tag_t                  r_tags [ROM_LATENCY];

  logic                  w_accept;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_final_issue;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_drain_done;
  logic [SUM_W-1:0]      w_inflight;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH:0]   w_fifo_head;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      w_inflight = w_inflight + SUM_W'(r_tags[i].valid);
    end
  end

  // Credit check ignores a same-cycle pop so ready never reaches rom_addr.
  assign w_accept      = (r_state == ST_IDLE) && i_start;
  assign w_issue       = (r_state == ST_RUN) &&
                         ((SUM_W'(w_fifo_count) + w_inflight) < SUM_W'(FIFO_DEPTH));
  assign w_issue_last  = (r_addr == LAST_ADDR);
  assign w_final_issue = w_issue && w_issue_last &&
                         (r_pass == r_num_passes - PASS_WIDTH'(1));
  assign w_wr          = r_tags[ROM_LATENCY-1].valid;
  assign w_rd          = !w_fifo_empty && i_data_out_ready;
  // Leave DRAIN as the final word transfers, so done lands the cycle after it.
  assign w_drain_done  = (w_inflight == '0) &&
                         (w_fifo_empty || ((w_fifo_count == CNT_W'(1)) && w_rd));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = (i_num_passes != '0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (w_final_issue) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_done) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_pass       <= '0;
      r_num_passes <= '0;
      r_ce         <= 1'b0;
      for (int i = 0; i < ROM_LATENCY; i++) r_tags[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ce    <= 1'b1;
      if (w_accept) begin
        r_addr       <= '0;
        r_pass       <= '0;
        r_num_passes <= i_num_passes;
      end else if (w_issue) begin
        if (w_issue_last) begin
          r_addr <= '0;
          r_pass <= r_pass + PASS_WIDTH'(1);
        end else begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
      end
      // Tags travel with the ROM pipeline and pop out aligned with i_rom_q.
      r_tags[0].valid <= w_issue;
      r_tags[0].last  <= w_issue && w_issue_last;
      for (int i = 1; i < ROM_LATENCY; i++) r_tags[i] <= r_tags[i-1];
    end
  end

  weight_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_wr),
    .i_wdata ({r_tags[ROM_LATENCY-1].last, i_rom_q}),
    .i_rd    (w_rd),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  // rom_addr shows the next address to issue; it only moves on an issue.
  assign o_rom_addr       = r_addr;
  assign o_rom_ce         = r_ce;
  assign o_busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done           = (r_state == ST_DONE);
  assign o_data_out       = w_fifo_head[DATA_WIDTH-1:0];
  assign o_data_out_last  = !w_fifo_empty && w_fifo_head[DATA_WIDTH];
  assign o_data_out_valid = !w_fifo_empty;

`ifdef WEIGHT_STREAM_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_accept) begin
      r_stall_cycles <= '0;
    end else if (o_data_out_valid && !i_data_out_ready && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`else
  assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_weight_rom_stream_ctrl.sv
// Directed bench for weight_rom_stream_ctrl with a small ROM model (ram[i] = i)
// and a scoreboard of expected {last, data} words.
module tb_weight_rom_stream_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 4;
  localparam int LAT   = 2;
  localparam int PW    = 8;
  localparam int LOG_N = 1024;
  localparam logic [DW:0] SENTINEL = '1;

`ifdef WEIGHT_STREAM_STALL_CNT_EN
  localparam int STALL_EXP = 10;
`else
  localparam int STALL_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [PW-1:0] i_num_passes;
  logic          o_busy;
  logic          o_done;
  logic [AW-1:0] o_rom_addr;
  logic          o_rom_ce;
  logic [DW-1:0] i_rom_q = '0;
  logic [DW-1:0] o_data_out;
  logic          o_data_out_last;
  logic          o_data_out_valid;
  logic          i_data_out_ready;
  logic [31:0]   o_stall_cycles;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW:0] sb_q [$];
  int  xfer_cnt, first_xfer, last_xfer, done_cnt, done_cyc;
  bit  busy_log  [LOG_N];
  bit  done_log  [LOG_N];
  bit  valid_log [LOG_N];
  logic [AW-1:0] addr_log [LOG_N];
  bit  prev_stall = 1'b0;

  weight_rom_stream_ctrl #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (AW),
    .ROM_LATENCY (LAT),
    .PASS_WIDTH  (PW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_num_passes     (i_num_passes),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_rom_addr       (o_rom_addr),
    .o_rom_ce         (o_rom_ce),
    .i_rom_q          (i_rom_q),
    .o_data_out       (o_data_out),
    .o_data_out_last  (o_data_out_last),
    .o_data_out_valid (o_data_out_valid),
    .i_data_out_ready (i_data_out_ready),
    .o_stall_cycles   (o_stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) ? DW'(a) : 16'hDEAD;
  endfunction

  // Two-stage ROM: address in cycle c, data in cycle c+2.
  logic [DW-1:0] rom_s1 = '0;
  always @(posedge clk) begin
    if (o_rom_ce) begin
      rom_s1  <= rom_word(o_rom_addr);
      i_rom_q <= rom_s1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin : monitor
    logic [DW:0] obs_word;
    logic [DW:0] exp_word;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        obs_word = {o_data_out_last, o_data_out};
        if (cyc < LOG_N) begin
          busy_log[cyc]  = o_busy;
          done_log[cyc]  = o_done;
          valid_log[cyc] = o_data_out_valid;
          addr_log[cyc]  = o_rom_addr;
        end
        check("fifo_bound", 64'(dut.u_fifo.o_count <= 3'd4), 64'd1);
        if (prev_stall) check("hold_valid", 64'(o_data_out_valid), 64'd1);
        if (o_data_out_valid) begin
          exp_word = (sb_q.size() > 0) ? sb_q[0] : SENTINEL;
          check("head_word", 64'(obs_word), 64'(exp_word));
          if (i_data_out_ready) begin
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            xfer_cnt++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
          end
        end
        prev_stall = o_data_out_valid && !i_data_out_ready;
        if (o_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input int passes);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < DEPTH; i++) sb_q.push_back({(i == DEPTH - 1), DW'(i)});
  endtask

  // mode 0: always ready, 1: alternate, 2: random, 3: low for t0+4..t0+13
  task automatic drive_ready(input int mode, input int t0);
    case (mode)
      1:       i_data_out_ready = ((cyc % 2) == 0);
      2:       i_data_out_ready = ($urandom_range(0, 1) == 1);
      3:       i_data_out_ready = !((cyc >= t0 + 4) && (cyc < t0 + 14));
      default: i_data_out_ready = 1'b1;
    endcase
  endtask

  task automatic run_job(input int passes, input int mode, input int mid_off, output int t0);
    xfer_cnt   = 0;
    first_xfer = -1;
    last_xfer  = -1;
    done_cnt   = 0;
    done_cyc   = -1;
    push_job(passes);
    t0           = cyc;
    i_num_passes = PW'(passes);
    i_start      = 1'b1;
    drive_ready(mode, t0);
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      if (mid_off > 0 && cyc == t0 + mid_off) begin
        i_start      = 1'b1;
        i_num_passes = 8'd5;
      end else begin
        i_start = 1'b0;
      end
      drive_ready(mode, t0);
      tick();
    end
    i_start          = 1'b0;
    i_data_out_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin : stim
    int t0;
    rst              = 1'b1;
    i_start          = 1'b0;
    i_num_passes     = '0;
    i_data_out_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy",  64'(o_busy), 64'd0);
    check("rst_done",  64'(o_done), 64'd0);
    check("rst_addr",  64'(o_rom_addr), 64'd0);
    check("rst_ce",    64'(o_rom_ce), 64'd0);
    check("rst_valid", 64'(o_data_out_valid), 64'd0);
    check("rst_last",  64'(o_data_out_last), 64'd0);
    check("rst_stall", 64'(o_stall_cycles), 64'd0);
    rst = 1'b0;
    repeat (2) tick();
    check("ce_after_rst", 64'(o_rom_ce), 64'd1);

    // Single pass, full throughput, exact latencies.
    run_job(1, 0, 0, t0);
    check("t1_first_xfer", 64'(first_xfer - t0), 64'd4);
    check("t1_last_xfer",  64'(last_xfer - t0), 64'd11);
    check("t1_done_cyc",   64'(done_cyc - t0), 64'd12);
    check("t1_done_cnt",   64'(done_cnt), 64'd1);
    check("t1_words",      64'(xfer_cnt), 64'd8);
    check("t1_busy_t0",    64'(busy_log[t0]), 64'd0);
    check("t1_busy_t1",    64'(busy_log[t0+1]), 64'd1);
    check("t1_busy_t11",   64'(busy_log[t0+11]), 64'd1);
    check("t1_busy_t12",   64'(busy_log[t0+12]), 64'd0);
    check("t1_sb_empty",   64'(sb_q.size()), 64'd0);

    // Three passes back to back.
    run_job(3, 0, 0, t0);
    check("t2_words",    64'(xfer_cnt), 64'd24);
    check("t2_span",     64'(last_xfer - first_xfer), 64'd23);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);
    check("t2_done_cyc", 64'(done_cyc - last_xfer), 64'd1);
    check("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // Alternating and random backpressure.
    run_job(1, 1, 0, t0);
    check("t3a_words",    64'(xfer_cnt), 64'd8);
    check("t3a_done_cnt", 64'(done_cnt), 64'd1);
    check("t3a_sb_empty", 64'(sb_q.size()), 64'd0);
    run_job(1, 2, 0, t0);
    check("t3b_words",    64'(xfer_cnt), 64'd8);
    check("t3b_done_cnt", 64'(done_cnt), 64'd1);
    check("t3b_sb_empty", 64'(sb_q.size()), 64'd0);

    // Ten-cycle stall from the first valid: addresses 0..3 issued, then the
    // next address (4) waits on the bus until space frees.
    run_job(1, 3, 0, t0);
    check("t4_addr_t4",    64'(addr_log[t0+4]), 64'd3);
    check("t4_addr_t5",    64'(addr_log[t0+5]), 64'd4);
    check("t4_addr_t13",   64'(addr_log[t0+13]), 64'd4);
    check("t4_first_xfer", 64'(first_xfer - t0), 64'd14);
    check("t4_words",      64'(xfer_cnt), 64'd8);
    check("t4_stall",      64'(o_stall_cycles), 64'(STALL_EXP));
    check("t4_sb_empty",   64'(sb_q.size()), 64'd0);

    // Start pulsed mid-job must be ignored.
    run_job(3, 0, 6, t0);
    check("t5_words",    64'(xfer_cnt), 64'd24);
    check("t5_done_cnt", 64'(done_cnt), 64'd1);
    check("t5_sb_empty", 64'(sb_q.size()), 64'd0);
    check("t5_stall",    64'(o_stall_cycles), 64'd0);

    // Zero-pass job: done next cycle, nothing streamed.
    done_cnt     = 0;
    t0           = cyc;
    i_num_passes = '0;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    check("zp_done_t1",  64'(done_log[t0+1]), 64'd1);
    check("zp_busy_t1",  64'(busy_log[t0+1]), 64'd0);
    check("zp_done_cnt", 64'(done_cnt), 64'd1);
    check("zp_no_valid", 64'(valid_log[t0+1] | valid_log[t0+2] | valid_log[t0+3] |
                             valid_log[t0+4]), 64'd0);

    // Asynchronous reset between edges in the middle of a pass.
    push_job(2);
    i_num_passes = 8'd2;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (8) tick();
    #1 rst = 1'b1;
    #1;
    check("ar_busy",  64'(o_busy), 64'd0);
    check("ar_valid", 64'(o_data_out_valid), 64'd0);
    check("ar_last",  64'(o_data_out_last), 64'd0);
    check("ar_addr",  64'(o_rom_addr), 64'd0);
    check("ar_ce",    64'(o_rom_ce), 64'd0);
    check("ar_done",  64'(o_done), 64'd0);
    check("ar_count", 64'(dut.u_fifo.o_count), 64'd0);
    sb_q.delete();
    done_cnt = 0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    check("ar_no_done",  64'(done_cnt), 64'd0);
    check("ar_idle_val", 64'(o_data_out_valid), 64'd0);
    run_job(1, 0, 0, t0);
    check("ar_first_xfer", 64'(first_xfer - t0), 64'd4);
    check("ar_words",      64'(xfer_cnt), 64'd8);
    check("ar_done_cnt",   64'(done_cnt), 64'd1);
    check("ar_sb_empty",   64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
